phase_tracker: RTL

Receiver-side monitor for the four-phase CPU clock set (PC, IMEM, DMEM, REG phases) produced by the phase clock generator. It samples the phase signals on the master clock and checks that they are one-hot, follow the fixed rotation, and hold for the expected length. Once it has verified the pattern, it emits registered single-cycle enable strobes and a 2-bit phase index. Downstream logic then runs on the master clock with enables instead of gated clocks, and an error flag and counter flag any phase-integrity fault.

---
 rtl/phase_tracker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/phase_tracker.sv
// Four-phase clock monitor: checks one-hot rotation and phase length, emits registered enables.
// Optional saturating fault counter is built only when PHASE_TRACKER_ERRCNT_EN is defined.
module phase_tracker #(
    parameter int unsigned PH_LEN   = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pc_ph,
    input  logic             imem_ph,
    input  logic             dmem_ph,
    input  logic             reg_ph,
    output logic             pc_en,
    output logic             imem_en,
    output logic             dmem_en,
    output logic             reg_en,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {StUnlocked, StLocked} state_t;

    localparam logic [3:0] LP_PH_LEN   = 4'(PH_LEN);
    localparam logic [3:0] LP_LOCK_CNT = 4'(LOCK_CNT);

    state_t     r_state, w_state_d;
    logic [3:0] r_s_ph;
    logic [3:0] r_prev_ph;
    logic [3:0] r_len, w_len_d;
    logic [3:0] r_good, w_good_d;
    logic [3:0] r_en, w_en_d;
    logic [1:0] r_phase, w_phase_d;
    logic       r_err, w_err_d;

    logic       w_valid;
    logic       w_prev_valid;
    logic       w_changed;
    logic       w_correct;
    logic       w_over;
    logic       w_fault;
    logic [3:0] w_next_exp;
    logic [3:0] w_good_inc;
    logic [1:0] w_idx;

    assign w_valid      = (r_s_ph != 4'd0) && ((r_s_ph & (r_s_ph - 4'd1)) == 4'd0);
    assign w_prev_valid = (r_prev_ph != 4'd0) && ((r_prev_ph & (r_prev_ph - 4'd1)) == 4'd0);
    assign w_changed    = (r_s_ph != r_prev_ph);
    // Bit 0 is PC, so the rotation PC->IMEM->DMEM->REG->PC is a left rotate.
    assign w_next_exp   = {r_prev_ph[2:0], r_prev_ph[3]};
    assign w_correct    = w_changed && w_valid && w_prev_valid &&
                          (r_s_ph == w_next_exp) && (r_len == LP_PH_LEN);
    // Another cycle of the same pattern would push the count to PH_LEN+1.
    assign w_over       = !w_changed && (r_len >= LP_PH_LEN);
    assign w_fault      = !w_valid || (w_changed && !w_correct) || w_over;
    assign w_good_inc   = r_good + 4'd1;
    assign w_len_d      = w_changed ? 4'd1 : ((r_len == 4'd15) ? 4'd15 : r_len + 4'd1);

    always_comb begin
        w_idx = 2'd0;
        unique case (r_s_ph)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_good_d  = r_good;
        w_en_d    = 4'd0;
        w_phase_d = r_phase;
        w_err_d   = 1'b0;
        unique case (r_state)
            StUnlocked: begin
                if (w_fault) begin
                    w_good_d = 4'd0;
                end else if (w_correct) begin
                    if (w_good_inc == LP_LOCK_CNT) begin
                        w_state_d = StLocked;
                        w_good_d  = 4'd0;
                        w_en_d    = r_s_ph;
                        w_phase_d = w_idx;
                    end else begin
                        w_good_d = w_good_inc;
                    end
                end
            end
            StLocked: begin
                if (w_fault) begin
                    w_state_d = StUnlocked;
                    w_good_d  = 4'd0;
                    w_err_d   = 1'b1;
                end else if (w_correct) begin
                    w_en_d    = r_s_ph;
                    w_phase_d = w_idx;
                end
            end
            default: w_state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= StUnlocked;
            r_s_ph    <= 4'd0;
            r_prev_ph <= 4'd0;
            r_len     <= 4'd0;
            r_good    <= 4'd0;
            r_en      <= 4'd0;
            r_phase   <= 2'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_s_ph    <= {reg_ph, dmem_ph, imem_ph, pc_ph};
            r_prev_ph <= r_s_ph;
            r_len     <= w_len_d;
            r_good    <= w_good_d;
            r_en      <= w_en_d;
            r_phase   <= w_phase_d;
            r_err     <= w_err_d;
        end
    end

`ifdef PHASE_TRACKER_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err_d && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign {reg_en, dmem_en, imem_en, pc_en} = r_en;
    assign phase  = r_phase;
    assign locked = (r_state == StLocked);
    assign err    = r_err;

endmodule
